// File: rtl/seg_reader.sv
// Seven-segment pattern reader: synchronizes the active-low segment lines,
// debounces them with a candidate/stability filter, decodes accepted
// patterns to a hex digit and checks that successive digits count upward.
module seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLK100MHZ,
    input  logic       BTND,
    input  logic       CA,
    input  logic       CB,
    input  logic       CC,
    input  logic       CD,
    input  logic       CE,
    input  logic       CF,
    input  logic       CG,
    output logic [3:0] digit,
    output logic       valid,
    output logic       blank,
    output logic       bad,
    output logic       upd,
    output logic [7:0] upd_cnt,
    output logic       seq_err
);

    localparam logic [6:0] BLANK_PAT  = 7'b1111111;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    typedef enum logic {
        NOBASE,
        BASED
    } chk_state_t;

    // Map an active-low segment pattern to {legal, value}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0010000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b1000110: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [6:0] pat_raw;
    logic [6:0] sync1;
    logic [6:0] sync2;
    logic [6:0] cand;
    logic [6:0] committed;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       accept;
    logic       cand_legal;
    logic [3:0] cand_value;
    logic       cand_blank;
    logic       seq_err_d;
    chk_state_t state;
    chk_state_t state_next;

    assign pat_raw = {CG, CF, CE, CD, CC, CB, CA};
    assign {cand_legal, cand_value} = decode(cand);
    assign cand_blank = (cand == BLANK_PAT);

    // Two-flop synchronizer on every segment line.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, giving a true two-stage chain.
    always_ff @(posedge CLK100MHZ or posedge BTND) begin
        if (BTND) begin
            sync1 <= BLANK_PAT;
            sync2 <= BLANK_PAT;
        end else begin
            sync1 <= pat_raw;
            sync2 <= sync1;
        end
    end

    // Stability counter next value and accept decision.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        accept   = 1'b0;
        if (sync2 != cand) begin
            cnt_next = 8'd1;
        end else begin
            if (cnt < STABLE_MAX) begin
                cnt_next = cnt + 8'd1;
            end
            accept = (cnt_next == STABLE_MAX) && (cand != committed);
        end
    end

    // Candidate, stability counter and committed pattern registers.
    always_ff @(posedge CLK100MHZ or posedge BTND) begin
        if (BTND) begin
            cand      <= BLANK_PAT;
            cnt       <= 8'd0;
            committed <= BLANK_PAT;
        end else begin
            cnt <= cnt_next;
            if (sync2 != cand) begin
                cand <= sync2;
            end
            if (accept) begin
                committed <= cand;
            end
        end
    end

    // Sequence checker state register.
    always_ff @(posedge CLK100MHZ or posedge BTND) begin
        if (BTND) begin
            state <= NOBASE;
        end else begin
            state <= state_next;
        end
    end

    // Sequence checker next state: legal accepts set a baseline, others drop it.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = cand_legal ? BASED : NOBASE;
        end
    end

    // Sequence checker output: digit still holds the previous legal value here.
    always_comb begin
        seq_err_d = 1'b0;
        if (accept && cand_legal && (state == BASED)) begin
            seq_err_d = (cand_value != 4'(digit + 4'd1)) && (cand_value != 4'h0);
        end
    end

    // Registered outputs, all updated on the accept edge.
    always_ff @(posedge CLK100MHZ or posedge BTND) begin
        if (BTND) begin
            digit   <= 4'h0;
            valid   <= 1'b0;
            blank   <= 1'b1;
            bad     <= 1'b0;
            upd     <= 1'b0;
            upd_cnt <= 8'd0;
            seq_err <= 1'b0;
        end else begin
            upd     <= accept;
            seq_err <= seq_err_d;
            if (accept) begin
                valid   <= cand_legal;
                blank   <= cand_blank;
                bad     <= !cand_legal && !cand_blank;
                upd_cnt <= upd_cnt + 8'd1;
                if (cand_legal) begin
                    digit <= cand_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader: table of patterns with hand-computed
// outputs, plus hand sequences for glitch rejection and reset mid-filter.
module tb_seg_reader;

    localparam int S = 4;

    logic       clk;
    logic       btnd;
    logic       ca, cb, cc, cd, ce, cf, cg;
    logic [3:0] digit;
    logic       valid, blank, bad, upd, seq_err;
    logic [7:0] upd_cnt;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt;

    typedef struct {
        logic [6:0] pat;
        logic       upd;
        logic [3:0] digit;
        logic       valid;
        logic       blank;
        logic       bad;
        logic       seq_err;
    } vec_t;

    vec_t vecs[$];

    logic [6:0] glyph [16];
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] JUNK  = 7'b0101010;

    seg_reader #(.STABLE_CYCLES(S)) dut (
        .CLK100MHZ(clk),
        .BTND     (btnd),
        .CA       (ca),
        .CB       (cb),
        .CC       (cc),
        .CD       (cd),
        .CE       (ce),
        .CF       (cf),
        .CG       (cg),
        .digit    (digit),
        .valid    (valid),
        .blank    (blank),
        .bad      (bad),
        .upd      (upd),
        .upd_cnt  (upd_cnt),
        .seq_err  (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_pat(input logic [6:0] p);
        {cg, cf, ce, cd, cc, cb, ca} = p;
    endtask

    function automatic vec_t mk(input logic [6:0] p, input logic u, input logic [3:0] d,
                                input logic v, input logic bl, input logic bd, input logic se);
        vec_t r;
        r.pat = p; r.upd = u; r.digit = d; r.valid = v;
        r.blank = bl; r.bad = bd; r.seq_err = se;
        return r;
    endfunction

    // Drive one pattern at a falling edge and hold it for 'hold' rising edges.
    // An expected accept must show upd on exactly edge S+2 and nowhere else.
    task automatic apply_vec(input vec_t v, input int hold, input string tag);
        @(negedge clk);
        set_pat(v.pat);
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (v.upd && i == S + 2) begin
                exp_cnt = exp_cnt + 8'd1;
                check({tag, " upd"},     upd,     1);
                check({tag, " seq_err"}, seq_err, v.seq_err);
                check({tag, " upd_cnt"}, upd_cnt, exp_cnt);
            end else begin
                check({tag, " no_upd"},  upd,     0);
                check({tag, " no_seq"},  seq_err, 0);
            end
        end
        check({tag, " digit"}, digit, v.digit);
        check({tag, " valid"}, valid, v.valid);
        check({tag, " blank"}, blank, v.blank);
        check({tag, " bad"},   bad,   v.bad);
        check({tag, " cnt"},   upd_cnt, exp_cnt);
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
        glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
        glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
        glyph[15] = 7'b0001110;

        // Phase A: idle blank, then 0..F, 0, 1, 2, 3 (all in sequence).
        vecs.push_back(mk(BLANK, 0, 4'h0, 0, 1, 0, 0));
        for (int d = 0; d < 16; d++) vecs.push_back(mk(glyph[d], 1, 4'(d), 1, 0, 0, 0));
        vecs.push_back(mk(glyph[0], 1, 4'h0, 1, 0, 0, 0));
        vecs.push_back(mk(glyph[1], 1, 4'h1, 1, 0, 0, 0));
        vecs.push_back(mk(glyph[2], 1, 4'h2, 1, 0, 0, 0));
        vecs.push_back(mk(glyph[3], 1, 4'h3, 1, 0, 0, 0));
        // Phase B: out-of-order values, bad, blank, restart, repeat.
        vecs.push_back(mk(glyph[2], 1, 4'h2, 1, 0, 0, 1));
        vecs.push_back(mk(glyph[5], 1, 4'h5, 1, 0, 0, 1));
        vecs.push_back(mk(glyph[6], 1, 4'h6, 1, 0, 0, 0));
        vecs.push_back(mk(JUNK,     1, 4'h6, 0, 0, 1, 0));
        vecs.push_back(mk(BLANK,    1, 4'h6, 0, 1, 0, 0));
        vecs.push_back(mk(glyph[7], 1, 4'h7, 1, 0, 0, 0));
        vecs.push_back(mk(glyph[7], 0, 4'h7, 1, 0, 0, 0));

        exp_cnt = 8'd0;
        set_pat(BLANK);
        btnd = 1'b1;
        #23;
        check("rst digit",   digit,   0);
        check("rst valid",   valid,   0);
        check("rst blank",   blank,   1);
        check("rst bad",     bad,     0);
        check("rst upd",     upd,     0);
        check("rst seq_err", seq_err, 0);
        check("rst upd_cnt", upd_cnt, 0);
        @(negedge clk);
        btnd = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], 10, $sformatf("vec%0d", i));
            if (i == 20) begin
                // Glitch of S-1 samples toward 1 while 3 is committed.
                @(negedge clk);
                set_pat(glyph[1]);
                repeat (S - 1) @(posedge clk);
                apply_vec(mk(glyph[3], 0, 4'h3, 1, 0, 0, 0), 10, "glitch");
            end
        end

        // Many accepts alternating 0 and 1; upd_cnt wraps through 255->0.
        for (int k = 0; k < 300; k++) begin
            apply_vec(mk(glyph[k % 2], 1, 4'(k % 2), 1, 0, 0, 0), S + 3, $sformatf("run%0d", k));
        end

        // Reset while a 4 is mid-filter, then re-accept after release.
        @(negedge clk);
        set_pat(glyph[4]);
        repeat (2) @(posedge clk);
        #3 btnd = 1'b1;
        #1;
        check("mid rst digit",   digit,   0);
        check("mid rst valid",   valid,   0);
        check("mid rst blank",   blank,   1);
        check("mid rst bad",     bad,     0);
        check("mid rst upd",     upd,     0);
        check("mid rst seq_err", seq_err, 0);
        check("mid rst upd_cnt", upd_cnt, 0);
        exp_cnt = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btnd = 1'b0;
        for (int i = 1; i <= S + 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post rst upd e%0d", i), upd, (i == S + 2) ? 1 : 0);
            if (i == S + 2) begin
                check("post rst digit",   digit,   4);
                check("post rst valid",   valid,   1);
                check("post rst seq_err", seq_err, 0);
                check("post rst upd_cnt", upd_cnt, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
